dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequences the single-port data memory for the MEM stage: accepts one load/store per handshake, drives
//  word-addressed BRAM with byte enables, waits the read latency, then returns aligned, sign/zero-extended
//  load data. It sits between the MEM-stage request and the memory output path, and it owns the stall (busy) toward the pipeline.
// PARAMETERS
//  ADDR_W   12  word-address width driven to memory (byte address bits [ADDR_W+1:2])
//  MEM_LAT  1   memory read latency in cycles, legal 1..4
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  reqValid   in   1       request present
//  reqReady   out  1       controller can accept (IDLE only)
//  reqAddr    in   32      byte address
//  reqOp      in   2       00 none, 01 load signed, 10 load unsigned, 11 store
//  reqSize    in   2       00 byte, 01 half, 10 word, 11 reserved
//  reqWdata   in   32      store data, right-justified
//  memEn      out  1       memory enable
//  memWe      out  4       byte write enables (0 for loads)
//  memAddr    out  ADDR_W  word address
//  memWdata   out  32      lane-shifted store data
//  memRdata   in   32      raw read word, valid MEM_LAT cycles after memEn
//  rspValid   out  1       one-cycle completion pulse (loads and stores)
//  rspData    out  32      extended load data; 0 for stores/faults
//  rspFault   out  1       misaligned/reserved access (macro only, else tied 0)
//  busy       out  1       !reqReady; pipeline stall
// BEHAVIOUR
//  Reset: state IDLE, reqReady=1, memEn=0, memWe=0, memAddr=0, memWdata=0, rspValid=0, rspData=0, rspFault=0, wait counter 0.
//  Accept = reqValid & reqReady & reqOp!=00 (cycle T); op 00 is ignored, state stays IDLE. Request fields are registered at T.
//  FSM IDLE -> ACCESS -> (load: WAIT) -> RESP -> IDLE. No back-to-back accept: reqReady=0 from T+1 until IDLE.
//  ACCESS (T+1): memEn=1, memAddr=addr[ADDR_W+1:2]; store: memWe per size/addr[1:0], memWdata replicated into
//   lanes (byte: {4{b}}, half: {2{h}}); load: memWe=0. Store -> RESP; load -> WAIT.
//  WAIT: counter 1..MEM_LAT; memEn=0; on count==MEM_LAT memRdata sampled, lane extracted by addr[1:0],
//   extended per reqOp (01 sign, 10 zero) into rspData; -> RESP.
//  RESP: rspValid=1 exactly one cycle; -> IDLE. Latency: store rspValid at T+2; load at T+2+MEM_LAT.
//  Byte enables: byte 0001<<a[1:0]; half a[1]?1100:0011; word 1111; reserved size treated as word.
//  Half extraction uses a[1] only; byte uses a[1:0]; a[0] ignored for half, a[1:0] ignored for word.
//  rspData/rspFault hold their value outside RESP; cleared only by the next RESP or reset.
//  Reset mid-operation: all outputs drop asynchronously, in-flight access is abandoned, no rspValid.
//  reqValid/fields changing while busy are ignored; no queueing.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN defined: half with a[0]=1, word with a[1:0]!=0, or size 11 -> ACCESS skipped,
//   memEn never asserted, RESP at T+1 with rspFault=1, rspData=0.
//  Undefined: no check, rspFault tied 0, low address bits ignored as stated above (forced alignment).
// STRUCTURE
//  dmem_pkg: op/size encodings (OP_NONE/LOAD/LOADU/STORE, SZ_B/H/W), state enum, MEM_LAT bounds.
//  Sub-module dmem_lane_align (combinational): byte-enable gen, store lane replication, load extract/extend,
//   misalign detect. Top holds FSM, wait counter, registers.
// TESTING
//  sw 0xDEADBEEF @0x10 -> T+1 memEn=1, memWe=1111, memAddr=4; rspValid at T+2, rspData=0.
//  sb 0x000000A5 @0x13 -> memWe=1000, memWdata=0xA5A5A5A5; then lb @0x13 -> rspData=0xFFFFFFA5; lbu -> 0x000000A5.
//  lh @0x12 with memRdata=0x8001_7FFF, MEM_LAT=3 -> rspValid at T+5, rspData=0xFFFF8001; lhu -> 0x00008001.
//  reqValid held high with op 00 for 5 cycles -> memEn never 1, reqReady stays 1; store then load back-to-back -> reqReady 0 between.
//  rst_n low in WAIT -> memEn/rspValid 0 immediately, state IDLE, no rspValid after release.
//  With DMEM_MISALIGN_TRAP_EN: lw @0x02 -> no memEn, rspValid+rspFault at T+1; without: reads word 0, rspFault=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage data memory access controller:
// request op/size codes, controller states and read-latency bounds.
package dmem_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_LOADU = 2'b10,
    OP_STORE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WAIT   = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request, memory and response signals of the data memory controller.
// The slave modport is the controller; master is the pipeline/memory side.
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 12
);

  logic              reqValid;
  logic              reqReady;
  logic [31:0]       reqAddr;
  logic [1:0]        reqOp;
  logic [1:0]        reqSize;
  logic [31:0]       reqWdata;
  logic              memEn;
  logic [3:0]        memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWdata;
  logic [31:0]       memRdata;
  logic              rspValid;
  logic [31:0]       rspData;
  logic              rspFault;
  logic              busy;

  modport master (
    output reqValid, reqAddr, reqOp, reqSize, reqWdata, memRdata,
    input  reqReady, memEn, memWe, memAddr, memWdata,
           rspValid, rspData, rspFault, busy
  );

  modport slave (
    input  reqValid, reqAddr, reqOp, reqSize, reqWdata, memRdata,
    output reqReady, memEn, memWe, memAddr, memWdata,
           rspValid, rspData, rspFault, busy
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane logic: store byte enables and lane replication, load lane extract
// and sign/zero extension, misalignment detect (only with DMEM_MISALIGN_TRAP_EN).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  stAddrLo,
  input  logic [1:0]  stSize,
  input  logic [31:0] stWdata,
  input  logic [1:0]  ldAddrLo,
  input  logic [1:0]  ldSize,
  input  logic [1:0]  ldOp,
  input  logic [31:0] ldRdata,
  output logic [3:0]  byteEn,
  output logic [31:0] laneWdata,
  output logic [31:0] loadData,
  output logic        misalign
);

  logic [7:0]  ldByte_s;
  logic [15:0] ldHalf_s;
  logic        signExt_s;

  // Store side: enables follow size and low address bits, reserved size acts as word
  always_comb begin
    byteEn    = 4'b1111;
    laneWdata = stWdata;
    case (stSize)
      SZ_B: begin
        byteEn    = 4'b0001 << stAddrLo;
        laneWdata = {4{stWdata[7:0]}};
      end
      SZ_H: begin
        byteEn    = stAddrLo[1] ? 4'b1100 : 4'b0011;
        laneWdata = {2{stWdata[15:0]}};
      end
      default: begin
        byteEn    = 4'b1111;
        laneWdata = stWdata;
      end
    endcase
  end

  // Load side: half uses addr[1] only, word ignores the low address bits
  always_comb begin
    ldByte_s  = ldRdata[8*ldAddrLo +: 8];
    ldHalf_s  = ldAddrLo[1] ? ldRdata[31:16] : ldRdata[15:0];
    signExt_s = (ldOp == OP_LOAD);
    loadData  = ldRdata;
    case (ldSize)
      SZ_B:    loadData = {{24{signExt_s & ldByte_s[7]}}, ldByte_s};
      SZ_H:    loadData = {{16{signExt_s & ldHalf_s[15]}}, ldHalf_s};
      default: loadData = ldRdata;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  // Trap detect on the incoming request
  always_comb begin
    misalign = 1'b0;
    case (stSize)
      SZ_H:    misalign = stAddrLo[0];
      SZ_W:    misalign = (stAddrLo != 2'b00);
      SZ_RSV:  misalign = 1'b1;
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory sequencer: one load/store per handshake, waits MEM_LAT
// for read data, returns extended load data. Trap mode via DMEM_MISALIGN_TRAP_EN.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_access_ctrl_if.slave  bus
);

  localparam int LAT_I = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                         (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam logic [2:0] LAT_C = 3'(LAT_I);

  state_e            state_r;
  state_e            nextState_s;
  logic [2:0]        waitCnt_r;
  logic [1:0]        op_r;
  logic [1:0]        size_r;
  logic [1:0]        addrLo_r;
  logic              reqReady_r;
  logic              busy_r;
  logic              memEn_r;
  logic [3:0]        memWe_r;
  logic [ADDR_W-1:0] memAddr_r;
  logic [31:0]       memWdata_r;
  logic              rspValid_r;
  logic [31:0]       rspData_r;
  logic              rspFault_r;
  logic              accept_s;
  logic [3:0]        byteEn_s;
  logic [31:0]       laneWdata_s;
  logic [31:0]       loadData_s;
  logic              misalign_s;
  logic              unusedAddrBits_s;

  assign accept_s         = bus.reqValid & reqReady_r & (bus.reqOp != OP_NONE);
  assign unusedAddrBits_s = ^bus.reqAddr[31:ADDR_W+2];

  dmem_lane_align u_align (
    .stAddrLo  (bus.reqAddr[1:0]),
    .stSize    (bus.reqSize),
    .stWdata   (bus.reqWdata),
    .ldAddrLo  (addrLo_r),
    .ldSize    (size_r),
    .ldOp      (op_r),
    .ldRdata   (bus.memRdata),
    .byteEn    (byteEn_s),
    .laneWdata (laneWdata_s),
    .loadData  (loadData_s),
    .misalign  (misalign_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state decode; a trapped request skips the memory access entirely
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (misalign_s) nextState_s = ST_RESP;
          else            nextState_s = ST_ACCESS;
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (op_r == OP_STORE) nextState_s = ST_RESP;
        else                  nextState_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (waitCnt_r == LAT_C) nextState_s = ST_RESP;
        else                    nextState_s = ST_WAIT;
      end
      ST_RESP: nextState_s = ST_IDLE;
      default: nextState_s = ST_IDLE;
    endcase
  end

  // Registered outputs, captured request fields and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt_r  <= 3'd0;
      op_r       <= 2'b00;
      size_r     <= 2'b00;
      addrLo_r   <= 2'b00;
      reqReady_r <= 1'b1;
      busy_r     <= 1'b0;
      memEn_r    <= 1'b0;
      memWe_r    <= 4'b0000;
      memAddr_r  <= {ADDR_W{1'b0}};
      memWdata_r <= 32'h0000_0000;
      rspValid_r <= 1'b0;
      rspData_r  <= 32'h0000_0000;
      rspFault_r <= 1'b0;
    end else begin
      reqReady_r <= (nextState_s == ST_IDLE);
      busy_r     <= (nextState_s != ST_IDLE);
      memEn_r    <= (nextState_s == ST_ACCESS);
      rspValid_r <= (nextState_s == ST_RESP);

      if (nextState_s == ST_WAIT) begin
        waitCnt_r <= (state_r == ST_WAIT) ? waitCnt_r + 3'd1 : 3'd1;
      end else begin
        waitCnt_r <= 3'd0;
      end

      if (accept_s) begin
        op_r     <= bus.reqOp;
        size_r   <= bus.reqSize;
        addrLo_r <= bus.reqAddr[1:0];
      end

      if (nextState_s == ST_ACCESS) begin
        memAddr_r <= bus.reqAddr[ADDR_W+1:2];
        if (bus.reqOp == OP_STORE) begin
          memWe_r    <= byteEn_s;
          memWdata_r <= laneWdata_s;
        end else begin
          memWe_r    <= 4'b0000;
        end
      end else begin
        memWe_r <= 4'b0000;
      end

      // Response payload only changes on entry to RESP
      if (nextState_s == ST_RESP) begin
        if (state_r == ST_WAIT) begin
          rspData_r  <= loadData_s;
          rspFault_r <= 1'b0;
        end else if (state_r == ST_IDLE) begin
          rspData_r  <= 32'h0000_0000;
          rspFault_r <= 1'b1;
        end else begin
          rspData_r  <= 32'h0000_0000;
          rspFault_r <= 1'b0;
        end
      end
    end
  end

  assign bus.reqReady = reqReady_r;
  assign bus.busy     = busy_r;
  assign bus.memEn    = memEn_r;
  assign bus.memWe    = memWe_r;
  assign bus.memAddr  = memAddr_r;
  assign bus.memWdata = memWdata_r;
  assign bus.rspValid = rspValid_r;
  assign bus.rspData  = rspData_r;
  assign bus.rspFault = rspFault_r;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with MEM_LAT=3; expected values are hand-computed.
// Checks the misaligned word load per DMEM_MISALIGN_TRAP_EN setting.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  localparam int ADDR_W  = 12;
  localparam int MEM_LAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic sawRsp;

  dmem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_access_ctrl #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns at the T+1 sample point
  task automatic issue(input logic [1:0] op, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.reqValid = 1'b1;
    bus.reqOp    = op;
    bus.reqSize  = size;
    bus.reqAddr  = addr;
    bus.reqWdata = wdata;
    step();
    bus.reqValid = 1'b0;
    bus.reqOp    = OP_NONE;
  endtask

  task automatic doStore(input string tag, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] expWe,
                         input logic [31:0] expWdata);
    issue(OP_STORE, size, addr, wdata);
    chk({tag, ".memEn"},    32'(bus.memEn),    32'd1);
    chk({tag, ".memWe"},    32'(bus.memWe),    32'(expWe));
    chk({tag, ".memAddr"},  32'(bus.memAddr),  32'(addr[ADDR_W+1:2]));
    chk({tag, ".memWdata"}, bus.memWdata,      expWdata);
    chk({tag, ".busy"},     32'(bus.busy),     32'd1);
    step();
    chk({tag, ".rspValid"}, 32'(bus.rspValid), 32'd1);
    chk({tag, ".rspData"},  bus.rspData,       32'h0);
    step();
    chk({tag, ".ready"},    32'(bus.reqReady), 32'd1);
  endtask

  task automatic doLoad(input string tag, input logic [1:0] op, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] rdata,
                        input logic [31:0] expData);
    bus.memRdata = rdata;
    issue(op, size, addr, 32'h0);
    chk({tag, ".memEn"},   32'(bus.memEn),   32'd1);
    chk({tag, ".memWe"},   32'(bus.memWe),   32'd0);
    chk({tag, ".memAddr"}, 32'(bus.memAddr), 32'(addr[ADDR_W+1:2]));
    for (int i = 0; i < MEM_LAT; i++) step();
    chk({tag, ".earlyRsp"}, 32'(bus.rspValid), 32'd0);
    step();
    chk({tag, ".rspValid"}, 32'(bus.rspValid), 32'd1);
    chk({tag, ".rspData"},  bus.rspData,       expData);
    chk({tag, ".rspFault"}, 32'(bus.rspFault), 32'd0);
    step();
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.reqValid = 1'b0;
    bus.reqOp    = OP_NONE;
    bus.reqSize  = SZ_W;
    bus.reqAddr  = 32'h0;
    bus.reqWdata = 32'h0;
    bus.memRdata = 32'h0;
    step();
    step();
    chk("rst.ready",    32'(bus.reqReady), 32'd1);
    chk("rst.busy",     32'(bus.busy),     32'd0);
    chk("rst.memEn",    32'(bus.memEn),    32'd0);
    chk("rst.memWe",    32'(bus.memWe),    32'd0);
    chk("rst.memAddr",  32'(bus.memAddr),  32'd0);
    chk("rst.memWdata", bus.memWdata,      32'h0);
    chk("rst.rspValid", 32'(bus.rspValid), 32'd0);
    chk("rst.rspData",  bus.rspData,       32'h0);
    chk("rst.rspFault", 32'(bus.rspFault), 32'd0);
    rst_n = 1'b1;
    step();

    doStore("sw",  SZ_W, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    doStore("sb",  SZ_B, 32'h0000_0013, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
    doStore("sh",  SZ_H, 32'h0000_0006, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);
    doLoad("lb",   OP_LOAD,  SZ_B, 32'h0000_0013, 32'hA5A5_A5A5, 32'hFFFF_FFA5);
    doLoad("lbu",  OP_LOADU, SZ_B, 32'h0000_0013, 32'hA5A5_A5A5, 32'h0000_00A5);
    doLoad("lh",   OP_LOAD,  SZ_H, 32'h0000_0012, 32'h8001_7FFF, 32'hFFFF_8001);
    doLoad("lhu",  OP_LOADU, SZ_H, 32'h0000_0012, 32'h8001_7FFF, 32'h0000_8001);
    doLoad("lhlo", OP_LOAD,  SZ_H, 32'h0000_0010, 32'h8001_7FFF, 32'h0000_7FFF);
    chk("hold.rspValid", 32'(bus.rspValid), 32'd0);
    chk("hold.rspData",  bus.rspData,       32'h0000_7FFF);

    // Op 00 with reqValid held is ignored
    bus.reqValid = 1'b1;
    bus.reqOp    = OP_NONE;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("nop.memEn", 32'(bus.memEn),    32'd0);
      chk("nop.ready", 32'(bus.reqReady), 32'd1);
    end

    // Store then load with reqValid held: no accept until IDLE again
    bus.reqOp    = OP_STORE;
    bus.reqSize  = SZ_W;
    bus.reqAddr  = 32'h0000_0020;
    bus.reqWdata = 32'h1122_3344;
    bus.memRdata = 32'hCAFE_F00D;
    step();
    bus.reqOp    = OP_LOAD;
    bus.reqAddr  = 32'h0000_0024;
    chk("b2b.t1.ready", 32'(bus.reqReady), 32'd0);
    chk("b2b.t1.memWe", 32'(bus.memWe),    32'hF);
    step();
    chk("b2b.t2.ready", 32'(bus.reqReady), 32'd0);
    chk("b2b.t2.rsp",   32'(bus.rspValid), 32'd1);
    step();
    chk("b2b.t3.ready", 32'(bus.reqReady), 32'd1);
    chk("b2b.t3.memEn", 32'(bus.memEn),    32'd0);
    step();
    bus.reqValid = 1'b0;
    bus.reqOp    = OP_NONE;
    chk("b2b.t4.memEn",   32'(bus.memEn),   32'd1);
    chk("b2b.t4.memWe",   32'(bus.memWe),   32'd0);
    chk("b2b.t4.memAddr", 32'(bus.memAddr), 32'd9);
    for (int i = 0; i < MEM_LAT + 1; i++) step();
    chk("b2b.ld.rsp",  32'(bus.rspValid), 32'd1);
    chk("b2b.ld.data", bus.rspData,       32'hCAFE_F00D);
    step();

    // Reset while waiting for read data
    issue(OP_LOAD, SZ_W, 32'h0000_0030, 32'h0);
    step();
    rst_n = 1'b0;
    #1;
    chk("rstw.memEn",    32'(bus.memEn),    32'd0);
    chk("rstw.rspValid", 32'(bus.rspValid), 32'd0);
    chk("rstw.ready",    32'(bus.reqReady), 32'd1);
    chk("rstw.rspData",  bus.rspData,       32'h0);
    step();
    rst_n  = 1'b1;
    sawRsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      sawRsp = sawRsp | bus.rspValid;
    end
    chk("rstw.noRsp", 32'(sawRsp),       32'd0);
    chk("rstw.idle",  32'(bus.reqReady), 32'd1);

`ifdef DMEM_MISALIGN_TRAP_EN
    bus.memRdata = 32'h1234_5678;
    issue(OP_LOAD, SZ_W, 32'h0000_0002, 32'h0);
    chk("trap.memEn",    32'(bus.memEn),    32'd0);
    chk("trap.rspValid", 32'(bus.rspValid), 32'd1);
    chk("trap.rspFault", 32'(bus.rspFault), 32'd1);
    chk("trap.rspData",  bus.rspData,       32'h0);
    step();
    chk("trap.done", 32'(bus.rspValid), 32'd0);
    chk("trap.ready", 32'(bus.reqReady), 32'd1);
`else
    doLoad("lwmis", OP_LOAD, SZ_W, 32'h0000_0002, 32'h1234_5678, 32'h1234_5678);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
